// File: rtl/ofifo_pkg.sv
// Shared accelerator constants: L0 geometry and output-FIFO defaults.
// No logic; pure parameters and small helpers.
// Nothing here carries state or backpressure.
package ofifo_pkg;

    // L0 input buffer geometry shared across the accelerator
    localparam int L0_BW  = 8;
    localparam int L0_ROW = 8;
    localparam int L0_COL = 8;

    // Output FIFO defaults: one lane per MAC-array column
    localparam int OFIFO_COL     = 8;
    localparam int OFIFO_PSUM_BW = 16;
    localparam int OFIFO_DEPTH   = 64;

    // Pointer width: address bits plus one wrap bit
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofifo_lane.sv
// One column's partial-sum FIFO with wrap-bit full/empty detection.
// Head is combinational from storage (zero read latency into the row register).
// Write to a full lane is dropped unless a pop frees the slot on the same edge.
module ofifo_lane
    import ofifo_pkg::*;
#(
    parameter int psum_bw = OFIFO_PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [psum_bw-1:0] din,
    input  logic               pop,
    output logic [psum_bw-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(depth);

    logic [AW:0]        wptr;
    logic [AW:0]        rptr;
    logic [psum_bw-1:0] mem [depth];
    logic               wr_acc;
    logic               pop_acc;

    // Full when addresses match but wrap bits differ; empty when pointers match
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);

    // A pop on the same edge makes room, so a full lane may still take the write
    assign wr_acc  = wr && (!full || pop_acc);
    assign pop_acc = pop && !empty;

    // Pointer update; reset discards all stored entries at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc)  wptr <= wptr + 1'b1;
            if (pop_acc) rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr[AW-1:0]] <= din;
    end

    assign dout = mem[rptr[AW-1:0]];

endmodule

// File: rtl/ofifo.sv
// Output FIFO: col independent lane FIFOs popped together as one row.
// Latency 1: popped row appears on out with a one-cycle o_valid pulse.
// Pop only when every lane holds data (o_ready); rd otherwise ignored.
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col     = OFIFO_COL,
    parameter int psum_bw = OFIFO_PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready
);

    logic [col-1:0]         lane_full;
    logic [col-1:0]         lane_empty;
    logic [col*psum_bw-1:0] head_row;
    logic                   pop;

    // A row pop needs data in every lane, so it is gated by o_ready
    assign pop = rd && o_ready;

    for (genvar i = 0; i < col; i++) begin : g_lane
        ofifo_lane #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[i]),
            .din   (in[psum_bw*i +: psum_bw]),
            .pop   (pop),
            .dout  (head_row[psum_bw*i +: psum_bw]),
            .full  (lane_full[i]),
            .empty (lane_empty[i])
        );
    end

    // Flags come only from registered pointers, so a same-cycle write is not visible
    assign o_full  = |lane_full;
    assign o_ready = ~|lane_empty;

    // Capture the popped heads; out holds between pops, o_valid pulses once per pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out     <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= pop;
            if (pop) out <= head_row;
        end
    end

endmodule

// File: tb/tb_ofifo.sv
module tb_ofifo;
    import ofifo_pkg::*;

    localparam int COL = OFIFO_COL;
    localparam int PBW = OFIFO_PSUM_BW;
    localparam int DEP = OFIFO_DEPTH;
    localparam int RW  = COL * PBW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [RW-1:0] in = '0;
    logic [COL-1:0] wr = '0;
    logic          rd = 1'b0;
    logic [RW-1:0] out;
    logic          o_valid;
    logic          o_full;
    logic          o_ready;

    ofifo #(.col(COL), .psum_bw(PBW), .depth(DEP)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .out     (out),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: one queue per lane, plus expected popped rows
    logic [PBW-1:0] mq [COL][$];
    logic [RW-1:0]  exp_q [$];
    logic [RW-1:0]  held = '0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic m_ready();
        for (int i = 0; i < COL; i++)
            if (mq[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int i = 0; i < COL; i++)
            if (mq[i].size() >= DEP) return 1'b1;
        return 1'b0;
    endfunction

    // One clock of stimulus; model applies the pop first, then the writes
    task automatic step(input logic [COL-1:0] w, input logic [RW-1:0] d, input logic r);
        logic          pop;
        logic [RW-1:0] row;
        logic [COL-1:0] was_full;
        @(negedge clk);
        chk("o_ready", RW'(o_ready), RW'(m_ready()));
        chk("o_full", RW'(o_full), RW'(m_full()));
        wr = w; in = d; rd = r;
        @(posedge clk);
        for (int i = 0; i < COL; i++) was_full[i] = (mq[i].size() >= DEP);
        pop = r && m_ready();
        if (pop) begin
            for (int i = 0; i < COL; i++) row[PBW*i +: PBW] = mq[i].pop_front();
            exp_q.push_back(row);
        end
        for (int i = 0; i < COL; i++)
            if (w[i] && (!was_full[i] || pop)) mq[i].push_back(d[PBW*i +: PBW]);
        #1;
        wr = '0; rd = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < COL; i++) mq[i].delete();
        exp_q.delete();
        held = '0;
        repeat (cycles) begin
            @(negedge clk);
            chk("rst_o_ready", RW'(o_ready), '0);
            chk("rst_o_full", RW'(o_full), '0);
            chk("rst_o_valid", RW'(o_valid), '0);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int i = 0; i < COL; i++) r[PBW*i +: PBW] = PBW'($urandom);
        return r;
    endfunction

    function automatic logic [RW-1:0] const_row(input logic [PBW-1:0] v);
        logic [RW-1:0] r;
        for (int i = 0; i < COL; i++) r[PBW*i +: PBW] = v;
        return r;
    endfunction

    // Monitor: every valid row must match the oldest expected pop; otherwise out holds
    initial begin
        logic [RW-1:0] e;
        forever begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_o_valid", RW'(o_valid), '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_row", out, e);
                    held = e;
                end
            end else begin
                chk("out_hold", out, held);
            end
        end
    end

    initial begin
        logic [RW-1:0] row;

        // Reset state
        apply_reset(2);
        @(negedge clk);
        chk("reset_out", out, '0);

        // Single full row, then pop
        for (int i = 0; i < COL; i++) row[PBW*i +: PBW] = PBW'(16'h0100 + i);
        step('1, row, 1'b0);
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);

        // Skewed column completion with premature pop requests
        for (int i = 0; i < COL; i++) step(COL'(1) << i, rand_row(), 1'b1);
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);

        // Overfill: 64 rows, then a dropped 16'hDEAD on lane 0, drain
        for (int k = 0; k < DEP; k++) step('1, rand_row(), 1'b0);
        step(COL'(1), const_row(16'hDEAD), 1'b0);
        for (int k = 0; k < DEP; k++) step('0, '0, 1'b1);
        step('0, '0, 1'b0);

        // All full, simultaneous pop and write of 16'hBEEF
        for (int k = 0; k < DEP; k++) step('1, rand_row(), 1'b0);
        step('1, const_row(16'hBEEF), 1'b1);
        for (int k = 0; k < DEP; k++) step('0, '0, 1'b1);
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);

        // Random interleaving across pointer wrap
        for (int k = 0; k < 500; k++)
            step(COL'($urandom), rand_row(), ($urandom_range(0, 9) < 6));
        for (int k = 0; k < 2 * DEP; k++) step('0, '0, 1'b1);

        // Reset with 10 rows stored, then fresh traffic
        for (int k = 0; k < 10; k++) step('1, rand_row(), 1'b0);
        apply_reset(3);
        @(negedge clk);
        chk("post_rst_out", out, '0);
        step('1, const_row(16'h5A5A), 1'b0);
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);

        // Every expected pop must have been observed
        chk("pending_rows", RW'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
